// File: rtl/clk_div_sched.sv
// Single-clock enable divider: emits a tick every 2^cur_sel enabled cycles plus a square wave,
// with ratio changes handed over via req/ack and applied only at a terminal-count boundary.
module clk_div_sched #(
    parameter int unsigned MAX_SEL = 4,
    parameter int unsigned DEF_SEL = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               sel_req,
    input  logic [2:0]         sel,
    output logic               sel_ack,
    output logic               sel_err,
    output logic               busy,
    output logic [2:0]         cur_sel,
    output logic [MAX_SEL-1:0] cnt,
    output logic               tick,
    output logic               div_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         pend_sel;
    logic [2:0]         pend_sel_nxt;
    logic               sel_err_nxt;
    logic               do_switch;
    logic [MAX_SEL:0]   span;
    logic [MAX_SEL:0]   span_m1;
    logic [MAX_SEL-1:0] term;
    logic               at_term;
    logic               sel_bad;

    // cur_sel never exceeds MAX_SEL, so the top bit of span-1 is always zero
    always_comb begin
        span    = (MAX_SEL + 1)'(1) << cur_sel;
        span_m1 = span - (MAX_SEL + 1)'(1);
        term    = span_m1[MAX_SEL-1:0];
        at_term = (cnt == term);
        sel_bad = (32'(sel) > MAX_SEL);
    end

    always_comb begin
        state_nxt    = state;
        pend_sel_nxt = pend_sel;
        sel_err_nxt  = 1'b0;
        do_switch    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_req) begin
                    if (sel_bad) begin
                        state_nxt   = ACK;
                        sel_err_nxt = 1'b1;
                    end else if (sel == cur_sel) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt    = PEND;
                        pend_sel_nxt = sel;
                    end
                end
            end
            PEND: begin
                // a frozen counter has no boundary to wait for, so switch immediately
                if (!en || at_term) begin
                    do_switch = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pend_sel <= '0;
            cnt      <= '0;
            cur_sel  <= 3'(DEF_SEL);
            tick     <= 1'b0;
            div_out  <= 1'b0;
            sel_ack  <= 1'b0;
            sel_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_sel <= pend_sel_nxt;
            tick     <= en && at_term;
            if (en && at_term) begin
                div_out <= ~div_out;
            end
            if (do_switch) begin
                cnt     <= '0;
                cur_sel <= pend_sel;
            end else if (en) begin
                cnt <= at_term ? '0 : cnt + 1'b1;
            end
            sel_ack <= (state_nxt == ACK);
            sel_err <= sel_err_nxt;
            busy    <= (state_nxt != IDLE);
        end
    end

endmodule
